// File: rtl/decode_ctrl_stage.sv
// ID-stage control decoder with a registered ID/EX control bundle,
// valid/ready handoff, multi-cycle issue throttle and stall counter.
// Ports: clk, rst_n, in_valid/in_ready/op (from decode), flush,
// ex_ready/out_valid plus control outputs (to execute), busy, stall_cnt.
module decode_ctrl_stage #(
  parameter int OP_W    = 3,
  parameter int FPU_LAT = 4,
  parameter int CRY_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic [1:0]       ALUop,
  output logic [1:0]       resmux,
  output logic             ALUSrc,
  output logic             branch,
  output logic             memwrite,
  output logic             a2src,
  output logic             regwrite,
  output logic             jump,
  output logic             cry_en,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       a2src;
    logic       regwrite;
    logic [1:0] resmux;
    logic       jump;
    logic       cry_en;
    logic       illegal;
  } ctrl_t;

  localparam int CW = 16;
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;

  // Wait counter preload: LAT-2, so the stage stalls LAT-1 cycles.
  localparam logic [CW-1:0] FPU_LD =
    (FPU_LAT > 1) ? CW'(FPU_LAT - 2) : '0;
  localparam logic [CW-1:0] CRY_LD =
    (CRY_LAT > 1) ? CW'(CRY_LAT - 2) : '0;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  ctrl_t         dec;
  ctrl_t         ctrl_q;
  logic          ov_q;
  logic          accept;
  logic          upper;
  logic          is_f;
  logic          is_cry;

  generate
    if (OP_W > 3) begin : g_upper
      assign upper = |op[OP_W-1:3];
    end else begin : g_noupper
      assign upper = 1'b0;
    end
  endgenerate

  always_comb begin
    dec = '0;
    if (upper) begin
      dec.illegal = 1'b1;
    end else begin
      unique case (op[2:0])
        3'b000: dec = ctrl_t'(13'b10_0_0_0_1_1_00_0_0_0);
        3'b001: dec = ctrl_t'(13'b00_1_0_0_0_1_01_0_0_0);
        3'b010: dec = ctrl_t'(13'b00_1_0_1_0_0_01_0_0_0);
        3'b011: dec = ctrl_t'(13'b10_1_0_0_0_1_00_0_0_0);
        3'b100: dec = ctrl_t'(13'b01_0_1_0_0_0_10_0_0_0);
        3'b101: dec = ctrl_t'(13'b00_0_0_0_0_1_10_1_0_0);
        3'b110: dec = ctrl_t'(13'b11_0_0_0_1_1_00_0_0_0);
        3'b111: dec = ctrl_t'(13'b00_0_0_0_1_1_11_0_1_0);
        default: dec = '0;
      endcase
    end
  end

  assign is_f   = !upper && (op[2:0] == 3'b110);
  assign is_cry = !upper && (op[2:0] == 3'b111);

  assign in_ready = !flush && (state == RUN) && (!ov_q || ex_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MC_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else if (flush) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept && is_f && FPU_LAT > 1) begin
            state <= MC_WAIT;
            cnt   <= FPU_LD;
          end else if (accept && is_cry && CRY_LAT > 1) begin
            state <= MC_WAIT;
            cnt   <= CRY_LD;
          end
        end
        MC_WAIT: begin
          if (cnt == '0) begin
            state <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      ctrl_q <= '0;
    end else if (flush) begin
      ov_q <= 1'b0;
    end else if (accept) begin
      ov_q   <= 1'b1;
      ctrl_q <= dec;
    end else if (ov_q && ex_ready) begin
      ov_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Drained register reads as a NOP downstream.
  assign out_valid = ov_q;
  assign {ALUop, ALUSrc, branch, memwrite, a2src, regwrite,
          resmux, jump, cry_en, illegal} =
    ov_q ? ctrl_q : '0;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed plan steps, then random
// traffic, all checked against a cycle-level behavioural model.
module tb_decode_ctrl_stage;

  localparam int OP_W  = 5;
  localparam int FLAT  = 4;
  localparam int CLAT  = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic             flush;
  logic             ex_ready;
  logic             out_valid;
  logic [1:0]       ALUop;
  logic [1:0]       resmux;
  logic             ALUSrc;
  logic             branch;
  logic             memwrite;
  logic             a2src;
  logic             regwrite;
  logic             jump;
  logic             cry_en;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // model state
  logic        m_ov;
  logic [12:0] m_ctrl;
  int          m_wait;
  int          m_stall;

  always #5 clk = ~clk;

  decode_ctrl_stage #(
    .OP_W(OP_W), .FPU_LAT(FLAT), .CRY_LAT(CLAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
    .ALUop(ALUop), .resmux(resmux), .ALUSrc(ALUSrc),
    .branch(branch), .memwrite(memwrite), .a2src(a2src),
    .regwrite(regwrite), .jump(jump), .cry_en(cry_en),
    .illegal(illegal), .busy(busy), .stall_cnt(stall_cnt)
  );

  function automatic logic [12:0] ref_dec(logic [OP_W-1:0] o);
    logic [12:0] t [8];
    t[0] = 13'b10_0_0_0_1_1_00_0_0_0;
    t[1] = 13'b00_1_0_0_0_1_01_0_0_0;
    t[2] = 13'b00_1_0_1_0_0_01_0_0_0;
    t[3] = 13'b10_1_0_0_0_1_00_0_0_0;
    t[4] = 13'b01_0_1_0_0_0_10_0_0_0;
    t[5] = 13'b00_0_0_0_0_1_10_1_0_0;
    t[6] = 13'b11_0_0_0_1_1_00_0_0_0;
    t[7] = 13'b00_0_0_0_1_1_11_0_1_0;
    if (int'(o) > 7) return 13'b1;
    return t[int'(o)];
  endfunction

  function automatic int ref_lat(logic [OP_W-1:0] o);
    if (int'(o) == 6) return FLAT;
    if (int'(o) == 7) return CLAT;
    return 1;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0;
    m_ctrl = '0;
    m_wait = 0;
    m_stall = 0;
  endtask

  task automatic chk_outs(string tag);
    logic [12:0] v;
    v = {ALUop, ALUSrc, branch, memwrite, a2src, regwrite,
         resmux, jump, cry_en, illegal};
    chk({tag, ".out_valid"}, int'(out_valid), int'(m_ov));
    chk({tag, ".ctrl"}, int'(v), m_ov ? int'(m_ctrl) : 0);
    chk({tag, ".busy"}, int'(busy), int'(m_wait > 0));
    chk({tag, ".stall_cnt"}, int'(stall_cnt), m_stall);
  endtask

  // One clock: drive at negedge, check ready, advance model at edge.
  task automatic cyc(string tag, logic iv, logic [OP_W-1:0] o,
                     logic fl, logic er);
    logic rdy;
    @(negedge clk);
    in_valid = iv;
    op = o;
    flush = fl;
    ex_ready = er;
    #1;
    rdy = !fl && m_wait == 0 && (!m_ov || er);
    chk({tag, ".in_ready"}, int'(in_ready), int'(rdy));
    @(posedge clk);
    if (iv && !rdy && m_stall < 15) m_stall++;
    if (fl) begin
      m_ov = 1'b0;
      m_wait = 0;
    end else if (iv && rdy) begin
      m_ov = 1'b1;
      m_ctrl = ref_dec(o);
      m_wait = ref_lat(o) - 1;
    end else begin
      if (m_ov && er) m_ov = 1'b0;
      if (m_wait > 0) m_wait--;
    end
    #1;
    chk_outs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    op = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = '0;
    flush = 1'b0;
    ex_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", int'(in_ready), 1);

    // back-to-back ops 000..101
    for (int i = 0; i < 6; i++)
      cyc("b2b", 1'b1, OP_W'(i), 1'b0, 1'b1);
    cyc("b2b_drain", 1'b0, '0, 1'b0, 1'b1);
    chk("b2b.stall0", int'(stall_cnt), 0);

    // FPU op, then 000 held: 3 wait cycles
    cyc("fpu", 1'b1, OP_W'(6), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc("fpu_hold", 1'b1, '0, 1'b0, 1'b1);
    chk("fpu.stall3", int'(stall_cnt), 3);
    cyc("fpu_drain", 1'b0, '0, 1'b0, 1'b1);

    // crypto op, flush on 3rd wait cycle
    do_reset();
    cyc("cry", 1'b1, OP_W'(7), 1'b0, 1'b1);
    chk("cry.cry_en", int'(cry_en), 1);
    chk("cry.resmux", int'(resmux), 3);
    cyc("cry_w1", 1'b0, '0, 1'b0, 1'b1);
    cyc("cry_w2", 1'b0, '0, 1'b0, 1'b1);
    cyc("cry_flush", 1'b0, '0, 1'b1, 1'b1);
    chk("flush.busy", int'(busy), 0);
    cyc("cry_after", 1'b1, OP_W'(1), 1'b0, 1'b1);

    // backpressure: 5 held cycles
    do_reset();
    cyc("bp_acc", 1'b1, OP_W'(3), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("bp_hold", 1'b1, OP_W'(4), 1'b0, 1'b0);
    chk("bp.stall5", int'(stall_cnt), 5);
    cyc("bp_rel", 1'b1, OP_W'(4), 1'b0, 1'b1);

    // illegal wide opcode
    cyc("illegal", 1'b1, 5'b01000, 1'b0, 1'b1);
    chk("illegal.flag", int'(illegal), 1);
    cyc("illegal_next", 1'b1, OP_W'(0), 1'b0, 1'b1);

    // stall counter saturation
    do_reset();
    cyc("sat_acc", 1'b1, OP_W'(0), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc("sat", 1'b1, OP_W'(0), 1'b0, 1'b0);
    chk("sat.value", int'(stall_cnt), 15);

    // async reset in the middle of a wait
    do_reset();
    cyc("ar_acc", 1'b1, OP_W'(7), 1'b0, 1'b1);
    cyc("ar_w", 1'b1, OP_W'(0), 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_outs("async_rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [OP_W-1:0] ro;
      ro = ($urandom_range(0, 9) == 0) ? OP_W'($urandom_range(8, 31))
                                       : OP_W'($urandom_range(0, 7));
      cyc("rand", 1'($urandom_range(0, 3) != 0), ro,
          1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, stall-aware control decoder for the pipelined CPU's ID stage. It decodes the opcode into datapath control signals, holds them in an ID/EX control register under a valid/ready handshake, and throttles issue for multi-cycle FPU and crypto instructions with a per-class latency counter. It sits between instruction fetch/decode and the execute stage, and replaces the purely combinational control decoder.

## Interface
- OP_W, 3 — opcode width, ≥3; any opcode with a nonzero bit above bit 2 is illegal
- FPU_LAT, 4 — issue latency of F-instructions in cycles, ≥1
- CRY_LAT, 8 — issue latency of crypto instructions in cycles, ≥1
- CNT_W, 16 — width of the stall performance counter

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  opcode on `op` is valid
- in_ready  out  1  stage accepts an opcode this cycle
- op  in  OP_W  instruction opcode
- flush  in  1  synchronous pipeline flush (branch/jump redirect)
- ex_ready  in  1  execute stage consumes the control register this cycle
- out_valid  out  1  control register holds a live instruction
- ALUop  out  2  ALU operation class
- resmux  out  2  result mux select
- ALUSrc, branch, memwrite, a2src, regwrite, jump, cry_en  out  1 each  datapath controls
- illegal  out  1  held instruction is an illegal opcode
- busy  out  1  multi-cycle issue wait in progress
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0

## Operation
- Decode, as {ALUop, ALUSrc, branch, memwrite, a2src, regwrite, resmux, jump, cry_en}:
  - 000 R: 10,0,0,0,1,1,00,0,0
  - 001 load: 00,1,0,0,0,1,01,0,0
  - 010 store: 00,1,0,1,0,0,01,0,0
  - 011 I: 10,1,0,0,0,1,00,0,0
  - 100 branch: 01,0,1,0,0,0,10,0,0
  - 101 jump: 00,0,0,0,0,1,10,1,0
  - 110 F: 11,0,0,0,1,1,00,0,0 (multi-cycle, FPU_LAT)
  - 111 crypto: 00,0,0,0,1,1,11,0,1 (multi-cycle, CRY_LAT)
  - Any other opcode (upper bits nonzero when OP_W>3): all controls 0, illegal=1, single-cycle.
- in_ready = !flush && state==RUN && (!out_valid || ex_ready). accept = in_valid && in_ready.
- On accept: the control register loads the decoded controls, and out_valid becomes 1.
- With no accept and out_valid && ex_ready: out_valid becomes 0.
- Whenever out_valid=0, all control outputs and illegal read 0, so the execute stage sees a NOP.
- FSM states:
  - RUN → MC_WAIT on accept of F/crypto with LAT>1, where cnt is loaded with LAT-2.
  - In MC_WAIT, cnt decrements each cycle; MC_WAIT → RUN in the cycle after the one in which cnt==0.
  - busy = (state==MC_WAIT).
- flush has highest priority: out_valid←0, state←RUN, cnt←0, and no accept that cycle. Flush has no effect on stall_cnt.
- stall_cnt increments when in_valid && !in_ready, including during flush. It saturates at all-ones and never wraps.

## Timing
- Reset (async, rst_n=0): out_valid=0, all control outputs 0, illegal=0, busy=0, state=RUN, cnt=0, stall_cnt=0. in_ready=1 once reset is released.
- Latency is 1 cycle: an opcode accepted at edge T appears on the outputs after edge T, with out_valid=1.
- Multi-cycle instruction accepted at edge T:
  - in_ready=0 for exactly LAT-1 cycles after T.
  - The earliest next accept is at edge T+LAT, provided out_valid has drained or ex_ready=1.
  - LAT=1 gives no wait cycles.
- Holding: if ex_ready=0 while out_valid=1, all outputs stay stable and in_ready=0 (backpressure). Holding and MC_WAIT overlap and do not add to each other.
- Reset asserted mid-MC_WAIT returns the block to the reset state immediately.

## Test plan
- Reset, then issue ops 000–101 back-to-back with ex_ready=1 → one instruction per cycle, each output vector matching the decode list 1 cycle after its accept, and stall_cnt=0.
- Op 110 with FPU_LAT=4, then 000 held on in_valid → in_ready low for 3 cycles, busy=1 for 3 cycles, 000 accepted on the 4th edge, stall_cnt=3.
- Op 111 with CRY_LAT=8 → cry_en=1 and resmux=11; flush asserted on the 3rd wait cycle → out_valid=0, busy=0, and in_ready=1 on the next cycle.
- ex_ready=0 for 5 cycles with out_valid=1 and in_valid=1 → outputs stable, in_ready=0, stall_cnt +5; ex_ready=1 → the next opcode is accepted.
- OP_W=5 with op=5'b01000 → illegal=1, every write/branch/jump control 0, no wait cycles.
- CNT_W=4 with 20 stall cycles → stall_cnt saturates at 15; rst_n pulsed low mid-MC_WAIT → all outputs 0 asynchronously.
